// File: rtl/complete_arbiter.sv
// Completion arbiter: buffers functional-unit results in small per-FU FIFOs and
// broadcasts up to CDB_SZ of them per cycle on the common data bus, picking
// FIFOs round-robin so no unit is starved.

package complete_arbiter_pkg;

  // Result packet produced by each functional unit.
  typedef struct packed {
    logic [5:0]  tag;
    logic [31:0] alu_result;
  } fu_packet_t;

endpackage

module complete_arbiter
  import complete_arbiter_pkg::*;
#(
  parameter int NUM_FU = 4,
  parameter int CDB_SZ = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic [NUM_FU-1:0]        fu_valid,
  input  fu_packet_t [NUM_FU-1:0]  fu_pack,
  output logic [NUM_FU-1:0]        fu_stall,
  output logic [CDB_SZ-1:0]        cdb_valid,
  output fu_packet_t [CDB_SZ-1:0]  cdb_pack
);

  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  // Per-FU two-entry FIFO: storage, read pointer and occupancy.
  fu_packet_t                mem_q [NUM_FU][2];
  logic [NUM_FU-1:0]         head_q;
  logic [NUM_FU-1:0]         head_d;
  logic [NUM_FU-1:0][1:0]    count_q;
  logic [NUM_FU-1:0][1:0]    count_d;
  logic [NUM_FU-1:0]         wr_idx;
  logic [NUM_FU-1:0]         enq;
  logic [NUM_FU-1:0]         deq;
  logic [NUM_FU-1:0]         nonempty;
  fu_packet_t [NUM_FU-1:0]   head_pkt;

  // Round-robin scan start and registered broadcast slots.
  logic [PTR_W-1:0]          rr_ptr_q;
  logic [PTR_W-1:0]          rr_ptr_d;
  logic [NUM_FU-1:0]         grant;
  logic [CDB_SZ-1:0]         cdb_valid_q;
  logic [CDB_SZ-1:0]         slot_valid_d;
  fu_packet_t [CDB_SZ-1:0]   cdb_pack_q;
  fu_packet_t [CDB_SZ-1:0]   slot_pack_d;

  // Distance of FU i from the round-robin start, walking upward with wrap.
  function automatic int scan_off(input int i, input logic [PTR_W-1:0] rr);
    int o;
    o = i - int'(rr);
    if (o < 0) o = o + NUM_FU;
    return o;
  endfunction

  // Stall comes straight from the occupancy flops so the FU sees no input-to-output path.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      fu_stall[i] = (count_q[i] == 2'd2);
      nonempty[i] = (count_q[i] != 2'd0);
      head_pkt[i] = mem_q[i][head_q[i]];
    end
  end

  // Grant selection: a non-empty FIFO's slot is the number of non-empty FIFOs ahead of it in scan order.
  always_comb begin : arb_comb
    int sel_rank;
    int off_i;
    int best_off;
    // NOTE: every output of this block gets a default first, so no path leaves a value held and no latch is inferred.
    grant        = '0;
    slot_valid_d = '0;
    slot_pack_d  = '0;
    rr_ptr_d     = rr_ptr_q;
    best_off     = -1;
    for (int i = 0; i < NUM_FU; i++) begin
      // NOTE: combinational temporaries use blocking '=' so later statements see the updated value; flops use '<='.
      off_i    = scan_off(i, rr_ptr_q);
      sel_rank = 0;
      for (int j = 0; j < NUM_FU; j++) begin
        if (j != i && nonempty[j] && scan_off(j, rr_ptr_q) < off_i) sel_rank = sel_rank + 1;
      end
      if (nonempty[i] && sel_rank < CDB_SZ) begin
        grant[i] = 1'b1;
        for (int s = 0; s < CDB_SZ; s++) begin
          if (sel_rank == s) begin
            slot_valid_d[s] = 1'b1;
            slot_pack_d[s]  = head_pkt[i];
          end
        end
        // The last FU granted in scan order sets where the next scan begins.
        if (off_i > best_off) begin
          best_off = off_i;
          rr_ptr_d = (i == NUM_FU - 1) ? '0 : PTR_W'(i + 1);
        end
      end
    end
  end

  // FIFO bookkeeping: a packet only enters at its arrival edge, so a held stalled value is never taken twice.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      enq[i]     = fu_valid[i] && !fu_stall[i] && !flush;
      deq[i]     = grant[i] && !flush;
      // With one entry held the write lands behind the head; with none it lands at the head.
      wr_idx[i]  = head_q[i] ^ (count_q[i] == 2'd1);
      head_d[i]  = head_q[i] ^ deq[i];
      case ({enq[i], deq[i]})
        2'b10:   count_d[i] = count_q[i] + 2'd1;
        2'b01:   count_d[i] = count_q[i] - 2'd1;
        default: count_d[i] = count_q[i];
      endcase
    end
  end

  // FIFO storage writes.
  // NOTE: the storage array has no reset; the counts alone decide which entries are live, so stale data is never read.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (enq[i]) mem_q[i][wr_idx[i]] <= fu_pack[i];
    end
  end

  // Occupancy and read pointers; flush empties every FIFO ahead of any enqueue or dequeue.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      head_q  <= '0;
    end else if (flush) begin
      count_q <= '0;
      head_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

  // Broadcast slots and round-robin pointer; flush clears the bus and restarts the scan at FU 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= '0;
      cdb_pack_q  <= '0;
    end else if (flush) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= '0;
      cdb_pack_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= slot_valid_d;
      cdb_pack_q  <= slot_pack_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_pack  = cdb_pack_q;

endmodule

// File: doc/complete_arbiter.md
COMPLETE_ARBITER -- requirements
Module: complete_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_FU, default 4, meaning the number of functional-unit result ports.
REQ-002 The block SHALL have parameter CDB_SZ, default 2, meaning the number of CDB broadcast slots per cycle, with 1 <= CDB_SZ <= NUM_FU.
REQ-003 The block SHALL have port clock  input  1  meaning the single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n  input  1  meaning reset, asynchronous and active-low.
REQ-005 The block SHALL have port flush  input  1  meaning a synchronous squash of all buffered results (branch mispredict).
REQ-006 The block SHALL have port fu_valid  input  NUM_FU  meaning the data_ready output of each FU.
REQ-007 The block SHALL have port fu_pack  input  NUM_FU x FU_PACKET  meaning the result packet of each FU.
REQ-008 The block SHALL have port fu_stall  output  NUM_FU  meaning the stall input of each FU; when high, the FU holds its output register.
REQ-009 The block SHALL have port cdb_valid  output  CDB_SZ  meaning that the broadcast slot carries a result.
REQ-010 The block SHALL have port cdb_pack  output  CDB_SZ x FU_PACKET  meaning the broadcast result per slot.

Function
REQ-011 The block SHALL keep one 2-entry FIFO per FU, with a 2-bit occupancy count per FU.
REQ-012 fu_stall[i] SHALL equal (count[i] == 2), decoded from flops only, with no combinational path from any input.
REQ-013 The block SHALL enqueue fu_pack[i] at the clock edge when fu_valid[i] && !fu_stall[i] && !flush.
- A value held by a stalled FU is never enqueued twice.
REQ-014 Each cycle, the arbiter SHALL select up to CDB_SZ non-empty FIFOs as follows:
- scan indices rr_ptr, rr_ptr+1, ... mod NUM_FU;
- the k-th selected FIFO's head goes to slot k;
- the selected heads are dequeued at the edge.
REQ-015 An empty FIFO SHALL NOT be granted, and a newly arriving fu_pack SHALL NOT be granted in its arrival cycle (no bypass).
REQ-016 A FIFO SHALL be dequeued and enqueued at the same edge when both apply; its count is then unchanged and order is preserved.
REQ-017 cdb_valid and cdb_pack SHALL be registered.
- Slot k is loaded with the k-th grant at the edge.
- Ungranted slots load cdb_valid=0 and cdb_pack=0.
REQ-018 Latency: fu_valid in cycle t with an empty FIFO and no contention SHALL produce cdb_valid in cycle t+2.
REQ-019 rr_ptr SHALL advance to (last granted index + 1) mod NUM_FU, and SHALL hold when no grant is made.
REQ-020 Per-FU order SHALL be preserved: results from one FU are broadcast in arrival order, never in the same cycle as each other.
REQ-021 When flush is high at an edge, the block SHALL apply all of the following, with priority over enqueue, dequeue and grant:
- all counts to 0;
- rr_ptr to 0;
- cdb_valid to 0 and cdb_pack to 0.
REQ-022 A result SHALL never be lost or duplicated.
- Each enqueued packet appears exactly once on the CDB unless a flush precedes its broadcast.

Reset
REQ-023 While reset_n is low, the block SHALL asynchronously force:
- all counts to 0 (so fu_stall=0);
- rr_ptr to 0;
- cdb_valid to 0 and cdb_pack to 0.
REQ-024 Reset asserted mid-operation SHALL discard all buffered results immediately, with no broadcast after reset_n rises until new enqueues occur.
REQ-025 FIFO storage SHALL need no reset; only counts and pointers are reset.

Verification
REQ-026 Single result: in cycle 1, fu_valid=4'b0001 with alu_result=0x10 -> cycle 3: cdb_valid=2'b01, cdb_pack[0].alu_result=0x10; cycle 4: cdb_valid=0.
REQ-027 Contention: all four FUs are valid in one cycle with results 0xA0..0xA3, rr_ptr=0, no further input.
- Cycle +2: slots broadcast 0xA0 and 0xA1.
- Cycle +3: slots broadcast 0xA2 and 0xA3.
- rr_ptr ends at 0.
REQ-028 Backpressure: FU0 is valid every cycle with incrementing values, CDB_SZ=1, and FU1..3 are also valid every cycle.
- fu_stall[0] rises once count[0]=2.
- Every FU0 value appears exactly once, in order.
REQ-029 Fairness: all FUs are valid continuously, CDB_SZ=2 -> the grant pairs rotate {0,1},{2,3},{0,1}, with no FU starved for more than 2 cycles.
REQ-030 Flush: with count=2 on FU0 and FU1, assert flush for one cycle while fu_valid=4'b1111.
- Next cycle: counts 0, fu_stall=0, cdb_valid=0.
- The cycle's inputs are not enqueued.
REQ-031 Async reset: drop reset_n mid-cycle while cdb_valid=2'b11 -> cdb_valid=0 and fu_stall=0 before the next clock edge.
